// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the register-file write port.
// ALU and load-unit writebacks are buffered in an in-order FIFO. One entry
// drains per clock into a registered write port. Pending writes, including
// the one currently on the port, can be looked up combinationally for
// operand bypass.
//
// Handshake: a request is accepted on a rising edge when its valid and its
// ready are both high. Ready depends only on the registered count, so ready
// never combinationally depends on the drain. mem_ready additionally depends
// on alu_valid, because a same-cycle ALU request claims a slot first. When
// both requests are accepted together, the ALU entry is the older of the two.
module reg_writeback_queue #(
    parameter int data_width    = 32,
    parameter int address_width = 5,
    parameter int fifo_depth    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [address_width-1:0]      alu_address_d,
    input  logic [data_width-1:0]         alu_data_dval,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [address_width-1:0]      mem_address_d,
    input  logic [data_width-1:0]         mem_data_dval,
    output logic                          mem_ready,
    output logic                          write_enable,
    output logic [address_width-1:0]      address_d,
    output logic [data_width-1:0]         data_dval,
    input  logic [address_width-1:0]      address_s1,
    input  logic [address_width-1:0]      address_s2,
    output logic                          fwd_s1_hit,
    output logic [data_width-1:0]         fwd_s1val,
    output logic                          fwd_s2_hit,
    output logic [data_width-1:0]         fwd_s2val,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          empty
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);

    logic [address_width-1:0] r_addr_mem [fifo_depth];
    logic [data_width-1:0]    r_data_mem [fifo_depth];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_we;
    logic [address_width-1:0] r_addr_out;
    logic [data_width-1:0]    r_data_out;

    logic                     w_alu_push;
    logic                     w_mem_push;
    logic                     w_pop;
    logic [PW-1:0]            w_mem_idx;
    logic [CW-1:0]            w_count_next;
    logic [data_width:0]      w_s1;
    logic [data_width:0]      w_s2;

    // Ready uses the registered count only. Because of that, count can never exceed the depth.
    assign alu_ready = (r_count <= (DEPTH - CW'(1)));
    assign mem_ready = (r_count <= (DEPTH - (alu_valid ? CW'(2) : CW'(1))));

    // Writes to r0 complete the handshake but are dropped, since r0 is never written.
    assign w_alu_push   = alu_valid && alu_ready && (alu_address_d != '0);
    assign w_mem_push   = mem_valid && mem_ready && (mem_address_d != '0);
    assign w_pop        = (r_count != '0);
    assign w_mem_idx    = r_wr_ptr + PW'(w_alu_push);
    assign w_count_next = r_count + CW'(w_alu_push) + CW'(w_mem_push) - CW'(w_pop);

    // Entry storage. No reset is needed because only slots counted by r_count are ever read.
    always_ff @(posedge clock) begin
        if (w_alu_push) begin
            r_addr_mem[r_wr_ptr] <= alu_address_d;
            r_data_mem[r_wr_ptr] <= alu_data_dval;
        end
        if (w_mem_push) begin
            r_addr_mem[w_mem_idx] <= mem_address_d;
            r_data_mem[w_mem_idx] <= mem_data_dval;
        end
    end

    // Pointers, occupancy and the registered write port. On each edge, the head moves into the port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr_out <= '0;
            r_data_out <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_alu_push) + PW'(w_mem_push);
            r_count  <= w_count_next;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_we       <= 1'b1;
                r_addr_out <= r_addr_mem[r_rd_ptr];
                r_data_out <= r_data_mem[r_rd_ptr];
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    // Scan the port register first (oldest), then FIFO entries from head to tail, so the youngest match wins.
    function automatic logic [data_width:0] lookup(input logic [address_width-1:0] a);
        logic [data_width:0] res;
        logic [PW-1:0]       idx;
        res = '0;
        idx = '0;
        if (a != '0) begin
            if (r_we && (r_addr_out == a)) begin
                res = {1'b1, r_data_out};
            end
            for (int i = 0; i < fifo_depth; i++) begin
                idx = r_rd_ptr + PW'(i);
                if ((CW'(i) < r_count) && (r_addr_mem[idx] == a)) begin
                    res = {1'b1, r_data_mem[idx]};
                end
            end
        end
        return res;
    endfunction

    // Bypass lookups. They see only committed-to-queue state, never same-cycle requests.
    always_comb begin
        w_s1 = lookup(address_s1);
        w_s2 = lookup(address_s2);
    end

    assign fwd_s1_hit   = w_s1[data_width];
    assign fwd_s1val    = w_s1[data_width-1:0];
    assign fwd_s2_hit   = w_s2[data_width];
    assign fwd_s2val    = w_s2[data_width-1:0];
    assign write_enable = r_we;
    assign address_d    = r_addr_out;
    assign data_dval    = r_data_out;
    assign count        = r_count;
    assign empty        = (r_count == '0) && !r_we;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue (default parameters: 32-bit data, 5-bit address, depth 4).
// Each expected commit is queued when its request is issued. A negedge monitor pops
// the queue and compares it against every write_enable pulse.
module tb_reg_writeback_queue;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_address_d;
  logic [31:0] alu_data_dval;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_address_d;
  logic [31:0] mem_data_dval;
  logic        mem_ready;
  logic        write_enable;
  logic [4:0]  address_d;
  logic [31:0] data_dval;
  logic [4:0]  address_s1;
  logic [4:0]  address_s2;
  logic        fwd_s1_hit;
  logic [31:0] fwd_s1val;
  logic        fwd_s2_hit;
  logic [31:0] fwd_s2val;
  logic [2:0]  count;
  logic        empty;

  logic [36:0] exp_q[$];
  int n_vec;
  int n_err;

  reg_writeback_queue dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_address_d(alu_address_d), .alu_data_dval(alu_data_dval),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_address_d(mem_address_d), .mem_data_dval(mem_data_dval),
    .mem_ready(mem_ready),
    .write_enable(write_enable), .address_d(address_d), .data_dval(data_dval),
    .address_s1(address_s1), .address_s2(address_s2),
    .fwd_s1_hit(fwd_s1_hit), .fwd_s1val(fwd_s1val),
    .fwd_s2_hit(fwd_s2_hit), .fwd_s2val(fwd_s2val),
    .count(count), .empty(empty)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset && write_enable) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_write: got addr=%0d data=%0h expected no write", address_d, data_dval);
      end else begin
        check("writeback", 64'({address_d, data_dval}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver: present one request pair for one edge, checking readiness before the edge
  task automatic req(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic exp_ar, input logic exp_mr);
    alu_valid = av; alu_address_d = aa; alu_data_dval = ad;
    mem_valid = mv; mem_address_d = ma; mem_data_dval = md;
    #1;
    check("alu_ready", 64'(alu_ready), 64'(exp_ar));
    check("mem_ready", 64'(mem_ready), 64'(exp_mr));
    if (av && exp_ar && aa != 5'd0) exp_q.push_back({aa, ad});
    if (mv && exp_mr && ma != 5'd0) exp_q.push_back({ma, md});
    @(posedge clock); #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drained(input string name);
    check({name, "_count"}, 64'(count), 64'd0);
    check({name, "_empty"}, 64'(empty), 64'd1);
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bypass1(input string name, input logic [4:0] a, input logic hit, input logic [31:0] val);
    address_s1 = a;
    #1;
    check({name, "_hit"}, 64'(fwd_s1_hit), 64'(hit));
    check({name, "_val"}, 64'(fwd_s1val), 64'(val));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    alu_valid = 1'b0; alu_address_d = '0; alu_data_dval = '0;
    mem_valid = 1'b0; mem_address_d = '0; mem_data_dval = '0;
    address_s1 = '0; address_s2 = '0;

    // 1 reset: requests during reset are not stored
    alu_valid = 1'b1; alu_address_d = 5'd7; alu_data_dval = 32'h77;
    tick(3);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_empty", 64'(empty), 64'd1);
    alu_valid = 1'b0;
    reset = 1'b1;
    tick(2);
    check("post_rst_count", 64'(count), 64'd0);

    // 2 single write: visible on the port exactly one cycle after acceptance
    req(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    check("single_count", 64'(count), 64'd1);
    check("single_we_n", 64'(write_enable), 64'd0);
    bypass1("single_fifo_fwd", 5'd5, 1'b1, 32'h1234);
    tick(1);
    check("single_we", 64'(write_enable), 64'd1);
    check("single_addr", 64'(address_d), 64'd5);
    check("single_data", 64'(data_dval), 64'h1234);
    bypass1("single_port_fwd", 5'd5, 1'b1, 32'h1234);
    tick(1);
    check("single_we_end", 64'(write_enable), 64'd0);
    check("single_addr_hold", 64'(address_d), 64'd5);
    bypass1("single_no_fwd", 5'd5, 1'b0, 32'h0);
    drained("single");

    // 3 simultaneous ALU and load to r3: ALU is older; bypass sees the load value
    address_s2 = 5'd4;
    req(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b1, 1'b1);
    check("simul_count", 64'(count), 64'd2);
    bypass1("simul_fwd_both", 5'd3, 1'b1, 32'hB);
    check("simul_s2_miss_hit", 64'(fwd_s2_hit), 64'd0);
    check("simul_s2_miss_val", 64'(fwd_s2val), 64'd0);
    tick(1);
    check("simul_first_data", 64'(data_dval), 64'hA);
    bypass1("simul_fwd_one_left", 5'd3, 1'b1, 32'hB);
    tick(1);
    check("simul_second_data", 64'(data_dval), 64'hB);
    tick(1);
    drained("simul");

    // 4a back-to-back ALU stream: one push and one pop per cycle keep count at 1
    for (int i = 1; i <= 6; i++) begin
      req(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
      check("stream_count", 64'(count), 64'd1);
    end
    tick(2);
    drained("stream");

    // 4b both sources every cycle: occupancy climbs to 3 and the load is then refused
    req(1'b1, 5'd10, 32'hA10, 1'b1, 5'd20, 32'hB20, 1'b1, 1'b1);
    check("fill_count1", 64'(count), 64'd2);
    req(1'b1, 5'd11, 32'hA11, 1'b1, 5'd21, 32'hB21, 1'b1, 1'b1);
    check("fill_count2", 64'(count), 64'd3);
    req(1'b1, 5'd12, 32'hA12, 1'b1, 5'd22, 32'hB22, 1'b1, 1'b0);
    check("fill_count3", 64'(count), 64'd3);
    req(1'b1, 5'd13, 32'hA13, 1'b1, 5'd23, 32'hB23, 1'b1, 1'b0);
    check("fill_count4", 64'(count), 64'd3);
    req(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'hB24, 1'b1, 1'b1);
    check("fill_count5", 64'(count), 64'd3);
    tick(4);
    drained("fill");

    // 5 register zero: handshake completes but nothing is written or forwarded
    req(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    check("r0_count", 64'(count), 64'd0);
    bypass1("r0_fwd", 5'd0, 1'b0, 32'h0);
    tick(1);
    check("r0_we", 64'(write_enable), 64'd0);

    // 6 reset mid-drain: three entries pending and one on the port, all discarded
    req(1'b1, 5'd14, 32'hE1, 1'b1, 5'd15, 32'hF1, 1'b1, 1'b1);
    req(1'b1, 5'd16, 32'hE2, 1'b1, 5'd17, 32'hF2, 1'b1, 1'b1);
    check("middrain_count", 64'(count), 64'd3);
    check("middrain_we", 64'(write_enable), 64'd1);
    @(negedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("middrain_rst_we", 64'(write_enable), 64'd0);
    check("middrain_rst_count", 64'(count), 64'd0);
    bypass1("middrain_rst_fwd", 5'd15, 1'b0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick(4);
    drained("middrain");

    // recovery after reset: pointers restart cleanly
    req(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    tick(3);
    drained("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
